// File: rtl/wb_result_broadcast.sv
// Writeback result broadcaster: per-unit hold registers for ALU/SFU/AGU completions,
// rotating grant of up to WB_PORTS units per cycle onto registered tag/data buses.
module wb_result_broadcast #(
  parameter int                TAG_W    = 6,
  parameter int                DATA_W   = 32,
  parameter int                WB_PORTS = 2,
  parameter logic [TAG_W-1:0]  NULL_TAG = {TAG_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid_ex,
  input  logic [TAG_W-1:0]  alu_rob_num_ex,
  input  logic [DATA_W-1:0] alu_result_ex,
  input  logic              alu_has_rd_ex,
  output logic              alu_ready_ex,
  output logic [TAG_W-1:0]  alu_rob_num_wb,
  output logic [DATA_W-1:0] alu_result_wb,
  output logic              alu_valid_wb,
  input  logic              sfu_valid_ex,
  input  logic [TAG_W-1:0]  sfu_rob_num_ex,
  input  logic [DATA_W-1:0] sfu_result_ex,
  input  logic              sfu_has_rd_ex,
  output logic              sfu_ready_ex,
  output logic [TAG_W-1:0]  sfu_rob_num_wb,
  output logic [DATA_W-1:0] sfu_result_wb,
  output logic              sfu_valid_wb,
  input  logic              agu_valid_ex,
  input  logic [TAG_W-1:0]  agu_rob_num_ex,
  input  logic [DATA_W-1:0] agu_result_ex,
  input  logic              agu_has_rd_ex,
  output logic              agu_ready_ex,
  output logic [TAG_W-1:0]  agu_rob_num_wb,
  output logic [DATA_W-1:0] agu_result_wb,
  output logic              agu_valid_wb
);

  localparam int         NU    = 3;
  localparam logic [1:0] U_ALU = 2'd0;

  // Handshake: a completion is taken at the edge where valid_ex && ready_ex.
  // ready_ex depends only on hold state, grant and flush, never on valid_ex.
  logic [NU-1:0]     in_valid, in_has_rd, ready, grant;
  logic [NU-1:0]     hold_valid, hold_rd, wb_valid;
  logic [TAG_W-1:0]  in_tag[NU], hold_tag[NU], wb_tag[NU];
  logic [DATA_W-1:0] in_data[NU], hold_data[NU], wb_data[NU];
  logic [1:0]        rr_ptr, first_denied, idx;
  logic [2:0]        scan, gcnt;
  logic              denied_any, tags_unique;

  assign in_valid  = {agu_valid_ex, sfu_valid_ex, alu_valid_ex};
  assign in_has_rd = {agu_has_rd_ex, sfu_has_rd_ex, alu_has_rd_ex};
  assign in_tag[0] = alu_rob_num_ex;
  assign in_tag[1] = sfu_rob_num_ex;
  assign in_tag[2] = agu_rob_num_ex;
  assign in_data[0] = alu_result_ex;
  assign in_data[1] = sfu_result_ex;
  assign in_data[2] = agu_result_ex;

  // Rotating scan from rr_ptr; the first valid hold beyond the port budget becomes next rr_ptr.
  always_comb begin
    grant        = '0;
    denied_any   = 1'b0;
    first_denied = rr_ptr;
    gcnt         = '0;
    scan         = '0;
    idx          = '0;
    for (int i = 0; i < NU; i++) begin
      scan = {1'b0, rr_ptr} + 3'(i);
      if (scan >= 3'(NU)) scan = scan - 3'(NU);
      idx = scan[1:0];
      if (hold_valid[idx]) begin
        if (gcnt < 3'(WB_PORTS)) begin
          grant[idx] = 1'b1;
          gcnt       = gcnt + 3'd1;
        end else if (!denied_any) begin
          denied_any   = 1'b1;
          first_denied = idx;
        end
      end
    end
  end

  assign ready = flush ? {NU{1'b1}} : (~hold_valid | grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= '0;
      hold_rd    <= '0;
      wb_valid   <= '0;
      rr_ptr     <= U_ALU;
      for (int u = 0; u < NU; u++) begin
        wb_tag[u]  <= NULL_TAG;
        wb_data[u] <= '0;
      end
    end else if (flush) begin
      hold_valid <= '0;
      wb_valid   <= '0;
      rr_ptr     <= U_ALU;
      for (int u = 0; u < NU; u++) wb_tag[u] <= NULL_TAG;
    end else begin
      for (int u = 0; u < NU; u++) begin
        wb_valid[u] <= grant[u];
        if (grant[u]) begin
          wb_data[u] <= hold_data[u];
          wb_tag[u]  <= hold_rd[u] ? hold_tag[u] : NULL_TAG;
        end else begin
          wb_tag[u] <= NULL_TAG;
        end
        if (in_valid[u] && ready[u]) begin
          hold_valid[u] <= 1'b1;
          hold_rd[u]    <= in_has_rd[u];
        end else if (grant[u]) begin
          hold_valid[u] <= 1'b0;
        end
      end
      if (denied_any) rr_ptr <= first_denied;
    end
  end

  // Payload needs no reset: it is only observed while hold_valid is set.
  always_ff @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (!flush && in_valid[u] && ready[u]) begin
        hold_tag[u]  <= in_tag[u];
        hold_data[u] <= in_data[u];
      end
    end
  end

  assign tags_unique =
    !((wb_tag[0] != NULL_TAG && wb_tag[0] == wb_tag[1]) ||
      (wb_tag[0] != NULL_TAG && wb_tag[0] == wb_tag[2]) ||
      (wb_tag[1] != NULL_TAG && wb_tag[1] == wb_tag[2]));

  always @(posedge clk) begin
    if (!rst) begin
      assert (tags_unique)
        else $error("wb_result_broadcast: duplicate tag on writeback buses %0h %0h %0h",
                    wb_tag[0], wb_tag[1], wb_tag[2]);
    end
  end

  assign alu_ready_ex   = ready[0];
  assign sfu_ready_ex   = ready[1];
  assign agu_ready_ex   = ready[2];
  assign alu_valid_wb   = wb_valid[0];
  assign sfu_valid_wb   = wb_valid[1];
  assign agu_valid_wb   = wb_valid[2];
  assign alu_rob_num_wb = wb_tag[0];
  assign sfu_rob_num_wb = wb_tag[1];
  assign agu_rob_num_wb = wb_tag[2];
  assign alu_result_wb  = wb_data[0];
  assign sfu_result_wb  = wb_data[1];
  assign agu_result_wb  = wb_data[2];

endmodule

// File: tb/tb_wb_result_broadcast.sv
// Bench for wb_result_broadcast: directed vectors, a queue-based grant model checked
// every cycle, and hand-computed literal expectations for the key scenarios.
module tb_wb_result_broadcast;

  localparam int         WB_PORTS = 2;
  localparam logic [5:0] NULL_T   = 6'h3F;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [2:0]  in_v, in_r, d_v, d_r;
  logic [5:0]  in_t[3], d_t[3];
  logic [31:0] in_d[3], d_d[3];

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;
  logic stream_on = 1'b0;
  int stream_cnt = 0;
  logic [5:0] exp_q[$];

  // Model state: per-unit hold and writeback bus contents, plus the scan start unit.
  logic        m_hv[3], m_hr[3], m_wv[3];
  logic [5:0]  m_ht[3], m_wt[3];
  logic [31:0] m_hd[3], m_wd[3];
  int          m_rr;
  logic [2:0]  m_g, c_g;
  int          m_nrr;
  logic        m_rdy;

  always #5 clk = ~clk;

  wb_result_broadcast dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid_ex(in_v[0]), .alu_rob_num_ex(in_t[0]), .alu_result_ex(in_d[0]),
    .alu_has_rd_ex(in_r[0]), .alu_ready_ex(d_r[0]), .alu_rob_num_wb(d_t[0]),
    .alu_result_wb(d_d[0]), .alu_valid_wb(d_v[0]),
    .sfu_valid_ex(in_v[1]), .sfu_rob_num_ex(in_t[1]), .sfu_result_ex(in_d[1]),
    .sfu_has_rd_ex(in_r[1]), .sfu_ready_ex(d_r[1]), .sfu_rob_num_wb(d_t[1]),
    .sfu_result_wb(d_d[1]), .sfu_valid_wb(d_v[1]),
    .agu_valid_ex(in_v[2]), .agu_rob_num_ex(in_t[2]), .agu_result_ex(in_d[2]),
    .agu_has_rd_ex(in_r[2]), .agu_ready_ex(d_r[2]), .agu_rob_num_wb(d_t[2]),
    .agu_result_wb(d_d[2]), .agu_valid_wb(d_v[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Units with a full hold, listed in rotation order from the scan start.
  function automatic logic [2:0] m_grant();
    int order[$];
    logic [2:0] g = '0;
    for (int k = 0; k < 3; k++) if (m_hv[(m_rr + k) % 3]) order.push_back((m_rr + k) % 3);
    for (int k = 0; k < order.size() && k < WB_PORTS; k++) g[order[k]] = 1'b1;
    return g;
  endfunction

  function automatic int m_next_rr();
    int order[$];
    for (int k = 0; k < 3; k++) if (m_hv[(m_rr + k) % 3]) order.push_back((m_rr + k) % 3);
    return (order.size() > WB_PORTS) ? order[WB_PORTS] : m_rr;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rr = 0;
      for (int u = 0; u < 3; u++) begin
        m_hv[u] = 1'b0; m_wv[u] = 1'b0; m_wt[u] = NULL_T; m_wd[u] = '0;
      end
    end else begin
      m_g   = m_grant();
      m_nrr = m_next_rr();
      if (flush) begin
        m_rr = 0;
        for (int u = 0; u < 3; u++) begin
          m_hv[u] = 1'b0; m_wv[u] = 1'b0; m_wt[u] = NULL_T;
        end
      end else begin
        for (int u = 0; u < 3; u++) begin
          m_rdy   = !m_hv[u] || m_g[u];
          m_wv[u] = m_g[u];
          m_wt[u] = (m_g[u] && m_hr[u]) ? m_ht[u] : NULL_T;
          if (m_g[u]) m_wd[u] = m_hd[u];
          if (in_v[u] && m_rdy) begin
            m_hv[u] = 1'b1; m_ht[u] = in_t[u]; m_hd[u] = in_d[u]; m_hr[u] = in_r[u];
          end else if (m_g[u]) begin
            m_hv[u] = 1'b0;
          end
        end
        m_rr = m_nrr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      c_g = m_grant();
      for (int u = 0; u < 3; u++) begin
        chk($sformatf("model_valid_wb[%0d]", u), 32'(d_v[u]), 32'(m_wv[u]));
        chk($sformatf("model_tag_wb[%0d]", u), 32'(d_t[u]), 32'(m_wt[u]));
        chk($sformatf("model_result_wb[%0d]", u), d_d[u], m_wd[u]);
        chk($sformatf("model_ready[%0d]", u), 32'(d_r[u]),
            32'(flush || !m_hv[u] || c_g[u]));
      end
      if (stream_on && d_v[0]) begin
        stream_cnt++;
        if (exp_q.size() > 0) chk("stream_tag", 32'(d_t[0]), 32'(exp_q.pop_front()));
        else chk("stream_extra", 32'(d_v[0]), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic [5:0] t, input logic [31:0] d, input logic r);
    in_v[u] = 1'b1; in_t[u] = t; in_d[u] = d; in_r[u] = r;
  endtask

  task automatic clear_in();
    in_v = '0; in_r = '0;
    for (int u = 0; u < 3; u++) begin in_t[u] = '0; in_d[u] = '0; end
  endtask

  task automatic chk_bus(input string name, input int u, input logic v, input logic [5:0] t);
    chk({name, "_valid"}, 32'(d_v[u]), 32'(v));
    chk({name, "_tag"}, 32'(d_t[u]), 32'(t));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clear_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;
    for (int u = 0; u < 3; u++) begin
      chk_bus($sformatf("reset_u%0d", u), u, 1'b0, NULL_T);
      chk($sformatf("reset_result_u%0d", u), d_d[u], 32'd0);
      chk($sformatf("reset_ready_u%0d", u), 32'(d_r[u]), 32'd1);
    end

    // Single ALU completion.
    drive(0, 6'd5, 32'hA5, 1'b1); tick(); clear_in();
    tick();
    chk_bus("single_b", 0, 1'b1, 6'd5);
    chk("single_data", d_d[0], 32'hA5);
    tick();
    chk_bus("single_after", 0, 1'b0, NULL_T);
    chk("single_data_hold", d_d[0], 32'hA5);

    // Triple contention from ALU.
    drive(0, 6'd1, 32'd100, 1'b1); drive(1, 6'd2, 32'd200, 1'b1); drive(2, 6'd3, 32'd300, 1'b1);
    tick(); clear_in();
    chk("tri_agu_ready", 32'(d_r[2]), 32'd0);
    chk("tri_alu_ready", 32'(d_r[0]), 32'd1);
    tick();
    chk_bus("tri_alu", 0, 1'b1, 6'd1);
    chk_bus("tri_sfu", 1, 1'b1, 6'd2);
    chk_bus("tri_agu_wait", 2, 1'b0, NULL_T);
    chk("tri_rr_agu", 32'(dut.rr_ptr), 32'd2);
    tick();
    chk_bus("tri_agu", 2, 1'b1, 6'd3);
    chk("tri_agu_data", d_d[2], 32'd300);
    chk_bus("tri_alu_idle", 0, 1'b0, NULL_T);

    // Store with no destination register.
    drive(2, 6'd9, 32'h99, 1'b0); tick(); clear_in();
    tick();
    chk_bus("nord_agu", 2, 1'b1, NULL_T);
    chk("nord_data", d_d[2], 32'h99);

    // Contention starting from AGU, with a back-to-back ALU accept.
    drive(0, 6'd30, 32'd30, 1'b1); drive(1, 6'd31, 32'd31, 1'b1); drive(2, 6'd32, 32'd32, 1'b1);
    tick(); clear_in();
    chk("rot_sfu_ready", 32'(d_r[1]), 32'd0);
    chk("rot_alu_ready", 32'(d_r[0]), 32'd1);
    drive(0, 6'd33, 32'd33, 1'b1);
    tick(); clear_in();
    chk_bus("rot_agu", 2, 1'b1, 6'd32);
    chk_bus("rot_alu", 0, 1'b1, 6'd30);
    chk_bus("rot_sfu_wait", 1, 1'b0, NULL_T);
    chk("rot_rr_sfu", 32'(dut.rr_ptr), 32'd1);
    tick();
    chk_bus("rot_sfu", 1, 1'b1, 6'd31);
    chk_bus("rot_alu_b2b", 0, 1'b1, 6'd33);

    // Flush with ALU/SFU holds full and a new ALU input in the flush cycle.
    drive(0, 6'd10, 32'd10, 1'b1); drive(1, 6'd11, 32'd11, 1'b1);
    tick(); clear_in();
    flush = 1'b1; drive(0, 6'd12, 32'd12, 1'b1);
    chk("flush_alu_ready", 32'(d_r[0]), 32'd1);
    tick(); flush = 1'b0; clear_in();
    chk_bus("flush_alu", 0, 1'b0, NULL_T);
    chk_bus("flush_sfu", 1, 1'b0, NULL_T);
    tick();
    chk_bus("flush_alu_late", 0, 1'b0, NULL_T);
    chk_bus("flush_sfu_late", 1, 1'b0, NULL_T);

    // ALU streaming, tags 0..9.
    stream_on = 1'b1; stream_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 6'(i), 32'(1000 + i), 1'b1);
      exp_q.push_back(6'(i));
      chk($sformatf("stream_ready_%0d", i), 32'(d_r[0]), 32'd1);
      tick();
    end
    clear_in();
    tick(); tick();
    stream_on = 1'b0;
    chk("stream_count", 32'(stream_cnt), 32'd10);
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of traffic.
    drive(0, 6'd40, 32'd40, 1'b1); drive(1, 6'd41, 32'd41, 1'b1); drive(2, 6'd42, 32'd42, 1'b1);
    tick(); clear_in();
    tick();
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      chk_bus($sformatf("midrst_u%0d", u), u, 1'b0, NULL_T);
      chk($sformatf("midrst_ready_u%0d", u), 32'(d_r[u]), 32'd1);
    end
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk_bus("midrst_agu_lost", 2, 1'b0, NULL_T);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
